dmem_loader: RTL

//  Upstream feeder for the pipeline top's data-memory preload port.
//  - Accepts a stream of DPW-bit words over a valid/ready handshake.
//  - Writes them through data_en/input_data/input_addr to consecutive word

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/dmem_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i pipeline and its helpers.
//   DPW           : datapath / address width of the core
//   ldr_state_t   : state encoding of the data-memory preload sequencer
//   LDR_ADDR_STEP : byte stride between consecutive preloaded words
package rv32i_pkg;

    localparam int DPW = 32;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2,
        LDR_ERR  = 2'd3
    } ldr_state_t;

    localparam int LDR_ADDR_STEP = 4;

endpackage

// File: rtl/dmem_loader.sv
// dmem_loader: streams words into the pipeline's D_cache preload port and
// keeps the core in reset until the whole image is written.
// Ports:
//   clk, arst_n              clock (rising edge), async active-low reset
//   start                    pulse: latch base_addr/word_count, begin a load
//   base_addr, word_count    byte address of first word, number of words
//   s_valid, s_data, s_ready valid/ready word stream in
//   data_en, input_data,     D_cache write strobe, data and byte address
//   input_addr               (one cycle after each accepted beat)
//   core_rst_n               low while a load is pending or rejected
//   busy, done, error        load in progress / finished / rejected
module dmem_loader #(
    parameter int DPW       = rv32i_pkg::DPW,
    parameter int CNTW      = 16,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic [DPW-1:0]  base_addr,
    input  logic [CNTW-1:0] word_count,
    input  logic            s_valid,
    input  logic [DPW-1:0]  s_data,
    output logic            s_ready,
    output logic            data_en,
    output logic [DPW-1:0]  input_data,
    output logic [DPW-1:0]  input_addr,
    output logic            core_rst_n,
    output logic            busy,
    output logic            done,
    output logic            error
);
    import rv32i_pkg::*;

    // Wide enough that base + 4*count can never wrap.
    localparam int XW = DPW + CNTW + 2;
    localparam logic [XW-1:0] MEM_BYTES = XW'(MEM_WORDS) * XW'(LDR_ADDR_STEP);

    ldr_state_t      stateR;
    ldr_state_t      nextState;
    logic [DPW-1:0]  addrR;
    logic [CNTW-1:0] remR;
    logic            sReadyR, busyR, doneR, errorR, coreRstNR;
    logic            dataEnR;
    logic [DPW-1:0]  inputDataR, inputAddrR;
    logic            sReadyNext, busyNext, doneNext, errorNext, coreRstNNext;
    logic [XW-1:0]   endAddr;
    logic            badCmd;
    logic            accept;
    logic            loadStart;

    // Command validation and handshake decode.
    always_comb begin
        endAddr = XW'(base_addr) + (XW'(word_count) * XW'(LDR_ADDR_STEP));
        badCmd  = (base_addr[1:0] != 2'b00) || (endAddr > MEM_BYTES);
        accept  = s_valid && sReadyR;
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stateR <= LDR_IDLE;
        end else begin
            stateR <= nextState;
        end
    end

    // Next-state logic; start is only honoured outside LOAD.
    always_comb begin
        nextState = stateR;
        case (stateR)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (!start) begin
                    nextState = stateR;
                end else if (badCmd) begin
                    nextState = LDR_ERR;
                end else if (word_count == '0) begin
                    nextState = LDR_DONE;
                end else begin
                    nextState = LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                if (accept && (remR == CNTW'(1'b1))) begin
                    nextState = LDR_DONE;
                end else begin
                    nextState = LDR_LOAD;
                end
            end
            default: nextState = LDR_IDLE;
        endcase
        loadStart = (stateR != LDR_LOAD) && (nextState == LDR_LOAD);
    end

    // Output decode from the upcoming state, so every status output is registered.
    always_comb begin
        sReadyNext   = 1'b0;
        busyNext     = 1'b0;
        doneNext     = 1'b0;
        errorNext    = 1'b0;
        coreRstNNext = 1'b0;
        case (nextState)
            LDR_IDLE: sReadyNext = 1'b0;
            LDR_LOAD: begin
                sReadyNext = 1'b1;
                busyNext   = 1'b1;
            end
            LDR_DONE: begin
                doneNext     = 1'b1;
                // Release only once DONE has lasted a cycle: the final write
                // strobe lands in the first DONE cycle and must drain first.
                coreRstNNext = (stateR == LDR_DONE);
            end
            LDR_ERR:  errorNext = 1'b1;
            default:  sReadyNext = 1'b0;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sReadyR   <= 1'b0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            errorR    <= 1'b0;
            coreRstNR <= 1'b0;
        end else begin
            sReadyR   <= sReadyNext;
            busyR     <= busyNext;
            doneR     <= doneNext;
            errorR    <= errorNext;
            coreRstNR <= coreRstNNext;
        end
    end

    // Address/remaining counters and the one-cycle-delayed write port.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addrR      <= '0;
            remR       <= '0;
            dataEnR    <= 1'b0;
            inputDataR <= '0;
            inputAddrR <= '0;
        end else begin
            dataEnR <= accept;
            if (loadStart) begin
                addrR <= base_addr;
                remR  <= word_count;
            end else if (accept) begin
                addrR <= addrR + DPW'(LDR_ADDR_STEP);
                remR  <= remR - CNTW'(1'b1);
            end else begin
                addrR <= addrR;
                remR  <= remR;
            end
            if (accept) begin
                inputDataR <= s_data;
                inputAddrR <= addrR;
            end else begin
                inputDataR <= inputDataR;
                inputAddrR <= inputAddrR;
            end
        end
    end

    assign s_ready    = sReadyR;
    assign busy       = busyR;
    assign done       = doneR;
    assign error      = errorR;
    assign core_rst_n = coreRstNR;
    assign data_en    = dataEnR;
    assign input_data = inputDataR;
    assign input_addr = inputAddrR;

endmodule
